// File: rtl/aibnd_bsr_pkg.sv
// Shared types and default sizing for the AIB boundary-scan register sequencer.
package aibnd_bsr_pkg;

  localparam int unsigned BSR_MAX_LEN = 48;
  localparam int unsigned BSR_CNT_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } bsr_state_e;

endpackage

// File: rtl/aibnd_bsr_shreg.sv
// Boundary-scan data register: parallel-load/serial-out TX side plus an
// indexed single-bit capture register for the returning RX chain.
module aibnd_bsr_shreg
  import aibnd_bsr_pkg::*;
#(
  parameter int unsigned MAX_LEN = BSR_MAX_LEN,
  parameter int unsigned CNT_W   = BSR_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] load_data_i,
  input  logic               shift_i,
  input  logic               cap_we_i,
  input  logic [CNT_W-1:0]   cap_idx_i,
  input  logic               cap_bit_i,
  output logic               sout_o,
  output logic [MAX_LEN-1:0] cap_o
);

  logic [MAX_LEN-1:0] tx_q, tx_d;
  logic [MAX_LEN-1:0] rx_q, rx_d;

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load_i) begin
      tx_d = load_data_i;
      rx_d = '0;
    end else begin
      if (shift_i) tx_d = {1'b0, tx_q[MAX_LEN-1:1]};
      if (cap_we_i) begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
          if (cap_idx_i == CNT_W'(i)) rx_d[i] = cap_bit_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign sout_o = tx_q[0];
  assign cap_o  = rx_q;

endmodule

// File: rtl/aibnd_bsr_scan_seq.sv
// JTAG boundary-scan sequencer: CAPTURE / SHIFT / UPDATE over the AIB BSR
// chains, with abort, length clamping and registered control outputs.
module aibnd_bsr_scan_seq
  import aibnd_bsr_pkg::*;
#(
  parameter int unsigned MAX_LEN = BSR_MAX_LEN,
  parameter int unsigned CNT_W   = BSR_CNT_W
) (
  input  logic               jtag_clk,
  input  logic               jtag_rstb,
  input  logic               start,
  input  logic               cap_en,
  input  logic               upd_en,
  input  logic [CNT_W-1:0]   len,
  input  logic [MAX_LEN-1:0] tx_pattern,
  input  logic               abort,
  input  logic               jtag_rx_scan_out,
  output logic               jtag_clkdr_en,
  output logic               jtag_tx_scanen,
  output logic               jtag_rx_scanen,
  output logic               jtag_tx_scan_in,
  output logic               jtag_mode,
  output logic [MAX_LEN-1:0] rx_pattern,
  output logic               busy,
  output logic               done,
  output logic               err
);

  bsr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;
  logic             ready_q;
  logic             clkdr_q, txen_q, rxen_q, mode_q, busy_q, done_q;
  logic             accept, len_bad, in_shift, sout;
  logic [CNT_W-1:0] len_clamp;

  // ready_q holds off acceptance for the first edge after reset release
  assign accept    = (state_q == ST_IDLE) && start && ready_q;
  assign len_bad   = (len > CNT_W'(MAX_LEN));
  assign len_clamp = len_bad ? CNT_W'(MAX_LEN) : len;
  assign in_shift  = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    upd_d   = upd_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d = len_clamp;
          cnt_d = len_clamp;
          upd_d = upd_en;
          err_d = len_bad;
          if (len == '0)  state_d = ST_DONE;
          else if (cap_en) state_d = ST_CAPTURE;
          else             state_d = ST_SHIFT;
        end
      end
      ST_CAPTURE: state_d = abort ? ST_DONE : ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (abort)                      state_d = ST_DONE;
        else if (cnt_q <= CNT_W'(1))    state_d = upd_q ? ST_UPDATE : ST_DONE;
      end
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge jtag_clk or negedge jtag_rstb) begin
    if (!jtag_rstb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      clkdr_q <= 1'b0;
      txen_q  <= 1'b0;
      rxen_q  <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
      // Control outputs are registered from the next state so they align with it
      clkdr_q <= (state_d == ST_CAPTURE) || (state_d == ST_SHIFT);
      txen_q  <= (state_d == ST_SHIFT);
      rxen_q  <= (state_d == ST_SHIFT);
      mode_q  <= (state_d == ST_UPDATE);
      busy_q  <= (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) || (state_d == ST_UPDATE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  aibnd_bsr_shreg #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) u_shreg (
    .clk_i       (jtag_clk),
    .rst_n_i     (jtag_rstb),
    .load_i      (accept),
    .load_data_i (tx_pattern),
    .shift_i     (in_shift),
    .cap_we_i    (in_shift),
    .cap_idx_i   (len_q - cnt_q),
    .cap_bit_i   (jtag_rx_scan_out),
    .sout_o      (sout),
    .cap_o       (rx_pattern)
  );

  assign jtag_clkdr_en   = clkdr_q;
  assign jtag_tx_scanen  = txen_q;
  assign jtag_rx_scanen  = rxen_q;
  assign jtag_tx_scan_in = txen_q & sout;
  assign jtag_mode       = mode_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_aibnd_bsr_scan_seq.sv
// Scoreboard bench for aibnd_bsr_scan_seq: directed operations push expected
// results; a negedge monitor measures each operation and checks on done.
module tb_aibnd_bsr_scan_seq;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0, cap_en = 1'b0, upd_en = 1'b0, abort = 1'b0;
  logic [5:0]  len = '0;
  logic [47:0] tx_pattern = '0;
  logic        rx_out = 1'b0;
  logic        clkdr_en, tx_scanen, rx_scanen, tx_scan_in, mode, busy, done, err;
  logic [47:0] rx_pattern;

  typedef struct {
    logic [47:0] rx;
    logic [47:0] tx;
    logic        err;
    int          lat, clk, sh, mode, bsy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, t0 = 0, done_cnt = 0;
  int          m_clk = 0, m_sh = 0, m_mode = 0, m_bsy = 0;
  logic [47:0] m_tx = '0;
  logic [47:0] rx_src = '0;

  aibnd_bsr_scan_seq #(.MAX_LEN(48), .CNT_W(6)) dut (
    .jtag_clk         (clk),
    .jtag_rstb        (rstb),
    .start            (start),
    .cap_en           (cap_en),
    .upd_en           (upd_en),
    .len              (len),
    .tx_pattern       (tx_pattern),
    .abort            (abort),
    .jtag_rx_scan_out (rx_out),
    .jtag_clkdr_en    (clkdr_en),
    .jtag_tx_scanen   (tx_scanen),
    .jtag_rx_scanen   (rx_scanen),
    .jtag_tx_scan_in  (tx_scan_in),
    .jtag_mode        (mode),
    .rx_pattern       (rx_pattern),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: drives the RX chain return, measures each operation, checks on done
  always @(negedge clk) begin
    exp_t e;
    if (!rstb) begin
      m_clk = 0; m_sh = 0; m_mode = 0; m_bsy = 0; m_tx = '0; rx_out = 1'b0;
    end else begin
      if (clkdr_en) m_clk++;
      if (mode)     m_mode++;
      if (busy)     m_bsy++;
      if (tx_scanen) begin
        if (m_sh < 48) begin
          m_tx[m_sh] = tx_scan_in;
          rx_out     = rx_src[m_sh];
        end
        m_sh++;
      end else begin
        rx_out = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency",    48'(cyc - t0), 48'(e.lat));
          chk("clkdr_cyc",  48'(m_clk),    48'(e.clk));
          chk("shift_cyc",  48'(m_sh),     48'(e.sh));
          chk("mode_cyc",   48'(m_mode),   48'(e.mode));
          chk("busy_cyc",   48'(m_bsy),    48'(e.bsy));
          chk("tx_seq",     m_tx,          e.tx);
          chk("rx_pattern", rx_pattern,    e.rx);
          chk("err",        48'(err),      48'(e.err));
          chk("busy_at_done", 48'(busy),   48'(0));
        end
        m_clk = 0; m_sh = 0; m_mode = 0; m_bsy = 0; m_tx = '0;
        t0 = cyc + 1;
      end
    end
  end

  task automatic push(input int lat, clkc, sh, md, bsy, input logic [47:0] erx, etx, input logic eerr);
    exp_t e;
    e.lat = lat; e.clk = clkc; e.sh = sh; e.mode = md; e.bsy = bsy;
    e.rx = erx; e.tx = etx; e.err = eerr;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input bit c, u, ab, input logic [5:0] l, input logic [47:0] tx, src,
                    input int lat, clkc, sh, md, bsy, input logic [47:0] erx, etx, input logic eerr);
    @(negedge clk);
    cap_en = c; upd_en = u; len = l; tx_pattern = tx; abort = ab;
    rx_src = src; t0 = cyc; start = 1'b1;
    push(lat, clkc, sh, md, bsy, erx, etx, eerr);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    wait_empty(200);
  endtask

  initial begin
    int done_before;
    #12;
    chk("rst_clkdr", 48'(clkdr_en), 48'(0));
    chk("rst_busy",  48'(busy),     48'(0));
    chk("rst_done",  48'(done),     48'(0));
    chk("rst_err",   48'(err),      48'(0));
    chk("rst_rx",    rx_pattern,    48'(0));
    @(negedge clk); #2 rstb = 1'b1;
    repeat (3) @(negedge clk);

    // Capture + 8-bit shift + update; RX bits above len must stay 0
    op(1, 1, 0, 6'd8, 48'hA5, 48'hFFFF_FFFF_FF3C, 11, 9, 8, 1, 10, 48'h3C, 48'hA5, 1'b0);
    // len = 0 goes straight to DONE, clears rx_pattern
    op(1, 1, 0, 6'd0, 48'hFF, 48'hFFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 48'h0, 48'h0, 1'b0);
    // len > MAX_LEN clamps to 48 and sets err
    op(0, 0, 0, 6'd60, 48'h9E37_79B9_7F4A, 48'h1234_5678_9ABC, 49, 48, 48, 0, 48,
       48'h1234_5678_9ABC, 48'h9E37_79B9_7F4A, 1'b1);
    // legal len clears err; abort alongside start in IDLE loses to start
    op(1, 0, 1, 6'd4, 48'h6, 48'hFFFF_FFFF_FFFF, 6, 5, 4, 0, 5, 48'hF, 48'h6, 1'b0);

    // Abort during SHIFT cycle 3 of a 16-bit operation
    @(negedge clk);
    cap_en = 0; upd_en = 1; len = 6'd16; tx_pattern = 48'hBEEF;
    rx_src = 48'hFFFF_FFFF_FFF5; t0 = cyc; start = 1'b1;
    push(5, 4, 4, 0, 4, 48'h5, 48'hF, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_empty(50);

    // start held high: three back-to-back operations, DONE + IDLE between them
    @(negedge clk);
    cap_en = 0; upd_en = 0; len = 6'd2; tx_pattern = 48'h2; rx_src = 48'h1;
    t0 = cyc; start = 1'b1;
    for (int i = 0; i < 3; i++) push(3, 2, 2, 0, 2, 48'h1, 48'h2, 1'b0);
    wait_empty(100);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Reset pulsed during SHIFT of an over-length operation
    @(negedge clk);
    cap_en = 0; upd_en = 0; len = 6'd60; tx_pattern = 48'hFFFF_0000_FFFF;
    rx_src = 48'hFFFF_FFFF_FFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    done_before = done_cnt;
    chk("rst_mid_clkdr",  48'(clkdr_en),   48'(0));
    chk("rst_mid_txen",   48'(tx_scanen),  48'(0));
    chk("rst_mid_rxen",   48'(rx_scanen),  48'(0));
    chk("rst_mid_txin",   48'(tx_scan_in), 48'(0));
    chk("rst_mid_mode",   48'(mode),       48'(0));
    chk("rst_mid_busy",   48'(busy),       48'(0));
    chk("rst_mid_done",   48'(done),       48'(0));
    chk("rst_mid_err",    48'(err),        48'(0));
    chk("rst_mid_rx",     rx_pattern,      48'(0));
    @(negedge clk);
    // start already high at release: first edge must be ignored
    cap_en = 0; upd_en = 0; len = 6'd2; tx_pattern = 48'h2; rx_src = 48'h1;
    start = 1'b1;
    push(3, 2, 2, 0, 2, 48'h1, 48'h2, 1'b0);
    t0 = cyc + 1;
    #2 rstb = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_empty(50);
    repeat (4) @(negedge clk);
    chk("done_count_after_reset", 48'(done_cnt), 48'(done_before + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
